uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver: deserializes one UART frame (start, 8 data bits LSB-first, optional parity, 1 or 2 stop bits) from a single line into a byte. Sits between the pad-side RX line and the register/FIFO layer of the UART. Reports parity and framing errors alongside the byte. Baud timing is derived from the system clock by parameters.

## Interface
- p_clk_speed_hz, default 50_000_000: system clock frequency in Hz.
- p_baud_rate, default 9_600: line bit rate; bit period is BIT_CYC = p_clk_speed_hz / p_baud_rate clocks (integer division, 5208 at defaults).
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- enable_i  in  1  permits leaving IDLE; a frame already in progress always completes.
- data_i  in  1  serial RX line, idle high, asynchronous to clk_i.
- parity_en_i  in  1  1 = frame carries a parity bit after data.
- parity_sel_i  in  1  0 = even, 1 = odd parity.
- stop_bits_i  in  1  0 = one stop bit, 1 = two.
- data_o  out  8  last received byte, bit 0 = first data bit on the line.
- busy_o  out  1  frame reception in progress.
- data_ready_o  out  1  data_o holds a completed frame.
- parity_err_o  out  1  parity mismatch in last frame.
- framing_err_o  out  1  a stop bit sampled low in last frame.

## Operation
- data_i passes through a 2-flop synchronizer; all decisions use the synchronized value.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: if enable_i and line low -> START, load counter with BIT_CYC/2, busy_o=1, clear data_ready_o, parity_err_o, framing_err_o.
- START: at counter expiry (mid start bit) re-sample; high -> IDLE (false start, busy_o=0, no flags set); low -> DATA, counter = BIT_CYC.
- DATA: at each expiry shift sampled bit into bit index 0..7 (LSB first); after bit 7 -> PARITY if parity_en_i else STOP1.
- PARITY: sample bit; parity_err = (XOR of 8 data bits ^ parity bit) != parity_sel_i (even: total ones even; odd: total ones odd).
- STOP1: sample; low sets framing error. If stop_bits_i=0, frame ends here; else -> STOP2, sample second stop likewise.
- Frame end (final stop sample): data_o updated, data_ready_o=1, error outputs updated, busy_o=0, -> IDLE. Byte is delivered even with errors.
- Config inputs (parity_en_i, parity_sel_i, stop_bits_i) are sampled when leaving IDLE and held for the frame.
- data_ready_o and error flags hold until the next accepted start (START entry) or reset.
- enable_i low mid-frame: ignored; frame completes.

## Timing
- Reset: state IDLE, data_o=8'h00, busy_o=0, data_ready_o=0, parity_err_o=0, framing_err_o=0, counters and shift register cleared; reset mid-frame aborts immediately.
- Start detect latency: 2–3 clocks after falling edge (synchronizer).
- Samples occur at bit centre: BIT_CYC/2 + k*BIT_CYC clocks after start detection.
- busy_o falls and data_ready_o rises on the same clock, about half a bit period into the final stop bit, i.e. before the stop bit ends; a start bit immediately following the stop bit is caught.
- Tolerates ±2% baud mismatch over an 11-bit frame.

## Structure
- Shared package uart_pkg: state enum, BIT_CYC computation function, parity-type constants (even/odd) for reuse by uart_tx.
- One sub-module natural: uart_baud_counter (loadable down-counter, expiry pulse), reusable by TX.
- Synchronizer inline (2 flops).

## Test plan
- Back-to-back frames "H","E","L","L","O" (8'h48,45,4C,4C,4F), odd parity, 1 stop, 104.17 us/bit -> at end of each stop bit busy_o=0, data_ready_o=1, data_o equals sent byte.
- Parity: 8'h48 with odd parity and parity bit 0 -> parity_err_o=1, data_o=8'h48; parity bit 1 -> parity_err_o=0; even parity with bit 0 -> no error.
- Framing: stop bit driven low for 8'hA5 -> framing_err_o=1, data_ready_o=1, data_o=8'hA5.
- Two stop bits, 8'h3C, second stop low -> framing_err_o=1; both high -> busy_o stays high until second stop centre.
- False start: low glitch of BIT_CYC/4 clocks -> returns to IDLE, busy_o=0, data_ready_o unchanged; enable_i=0 with start bit -> no reception.
- Reset asserted mid DATA -> all outputs 0 immediately; next clean frame 8'h55 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bit-period helper and parity types.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } uart_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Clocks per bit; integer division truncates toward a slightly fast sampling rate.
  function automatic int calc_bit_cyc(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Loadable down-counter; expire_o is high in the cycle before the count would reach zero.
module uart_baud_counter #(
  parameter int p_width = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [p_width-1:0] load_val_i,
  output logic               expire_o
);

  logic [p_width-1:0] count_reg;

  // A load value of N makes expire_o act on the N-th rising edge after the load.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_reg <= '0;
    end else if (load_i) begin
      count_reg <= load_val_i;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expire_o = (count_reg == p_width'(1));

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter int p_clk_speed_hz = 50_000_000,
  parameter int p_baud_rate    = 9_600
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       data_i,
  input  logic       parity_en_i,
  input  logic       parity_sel_i,
  input  logic       stop_bits_i,
  output logic [7:0] data_o,
  output logic       busy_o,
  output logic       data_ready_o,
  output logic       parity_err_o,
  output logic       framing_err_o
);

  localparam int BIT_CYC = calc_bit_cyc(p_clk_speed_hz, p_baud_rate);
  localparam int CNT_W   = $clog2(BIT_CYC + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BIT_CYC);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BIT_CYC / 2);

  uart_state_e state_reg;
  logic [1:0]  sync_reg;
  logic        rx_sync;
  logic [2:0]  bit_idx_reg;
  logic [7:0]  shift_reg;
  logic        par_en_reg, par_sel_reg, stop2_reg;
  logic        perr_pend_reg, ferr_pend_reg;
  logic [7:0]  data_reg;
  logic        busy_reg, ready_reg, perr_reg, ferr_reg;
  logic        cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic        baud_tick;

  // Synchronizer resets to the idle-high level so reset release never looks like a start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_reg <= 2'b11;
    else       sync_reg <= {sync_reg[0], data_i};
  end
  assign rx_sync = sync_reg[1];

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = FULL_CNT;
    if (state_reg == ST_IDLE) begin
      if (enable_i && !rx_sync) begin
        cnt_load = 1'b1;
        cnt_val  = HALF_CNT;
      end
    end else if (baud_tick) begin
      cnt_load = 1'b1;
    end
  end

  uart_baud_counter #(.p_width(CNT_W)) u_baud (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .expire_o   (baud_tick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      par_en_reg    <= 1'b0;
      par_sel_reg   <= 1'b0;
      stop2_reg     <= 1'b0;
      perr_pend_reg <= 1'b0;
      ferr_pend_reg <= 1'b0;
      data_reg      <= '0;
      busy_reg      <= 1'b0;
      ready_reg     <= 1'b0;
      perr_reg      <= 1'b0;
      ferr_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (enable_i && !rx_sync) begin
            state_reg     <= ST_START;
            busy_reg      <= 1'b1;
            ready_reg     <= 1'b0;
            perr_reg      <= 1'b0;
            ferr_reg      <= 1'b0;
            par_en_reg    <= parity_en_i;
            par_sel_reg   <= parity_sel_i;
            stop2_reg     <= stop_bits_i;
            bit_idx_reg   <= '0;
            perr_pend_reg <= 1'b0;
            ferr_pend_reg <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            if (rx_sync) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            shift_reg   <= {rx_sync, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) state_reg <= par_en_reg ? ST_PARITY : ST_STOP1;
          end
        end
        ST_PARITY: begin
          if (baud_tick) begin
            perr_pend_reg <= ((^shift_reg) ^ rx_sync) != par_sel_reg;
            state_reg     <= ST_STOP1;
          end
        end
        ST_STOP1: begin
          if (baud_tick) begin
            if (stop2_reg) begin
              ferr_pend_reg <= !rx_sync;
              state_reg     <= ST_STOP2;
            end else begin
              data_reg  <= shift_reg;
              ready_reg <= 1'b1;
              perr_reg  <= perr_pend_reg;
              ferr_reg  <= !rx_sync;
              busy_reg  <= 1'b0;
              state_reg <= ST_IDLE;
            end
          end
        end
        ST_STOP2: begin
          if (baud_tick) begin
            data_reg  <= shift_reg;
            ready_reg <= 1'b1;
            perr_reg  <= perr_pend_reg;
            ferr_reg  <= ferr_pend_reg | !rx_sync;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign data_o        = data_reg;
  assign busy_o        = busy_reg;
  assign data_ready_o  = ready_reg;
  assign parity_err_o  = perr_reg;
  assign framing_err_o = ferr_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level timing model plus per-cycle output compare and literal spot checks.
module tb_uart_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 50_000;
  localparam int BIT    = CLK_HZ / BAUD;
  localparam int HALF   = BIT / 2;

  localparam int EV_START = 0;
  localparam int EV_FALSE = 1;
  localparam int EV_END   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       rx = 1'b1;
  logic       pe = 1'b0, ps = 1'b0, st2 = 1'b0;
  logic [7:0] data;
  logic       busy, ready, perr, ferr;

  uart_rx #(.p_clk_speed_hz(CLK_HZ), .p_baud_rate(BAUD)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .data_i        (rx),
    .parity_en_i   (pe),
    .parity_sel_i  (ps),
    .stop_bits_i   (st2),
    .data_o        (data),
    .busy_o        (busy),
    .data_ready_o  (ready),
    .parity_err_o  (perr),
    .framing_err_o (ferr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    int         kind;
    logic [7:0] b;
    logic       pe_err;
    logic       fr_err;
  } ev_t;

  ev_t        evq[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  bit         chk_on = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic       exp_busy = 1'b0, exp_ready = 1'b0, exp_perr = 1'b0, exp_ferr = 1'b0;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: events are scheduled in absolute cycles; an event at N applies on the N-th rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      evq.delete();
      exp_data  <= 8'h00;
      exp_busy  <= 1'b0;
      exp_ready <= 1'b0;
      exp_perr  <= 1'b0;
      exp_ferr  <= 1'b0;
    end else if (evq.size() > 0 && evq[0].at == cyc + 1) begin
      ev_t e;
      e = evq.pop_front();
      case (e.kind)
        EV_START: begin
          exp_busy  <= 1'b1;
          exp_ready <= 1'b0;
          exp_perr  <= 1'b0;
          exp_ferr  <= 1'b0;
        end
        EV_FALSE: exp_busy <= 1'b0;
        default: begin
          exp_busy  <= 1'b0;
          exp_ready <= 1'b1;
          exp_data  <= e.b;
          exp_perr  <= e.pe_err;
          exp_ferr  <= e.fr_err;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      cmp("busy", {7'b0, busy}, {7'b0, exp_busy});
      cmp("ready", {7'b0, ready}, {7'b0, exp_ready});
      cmp("data", data, exp_data);
      cmp("perr", {7'b0, perr}, {7'b0, exp_perr});
      cmp("ferr", {7'b0, ferr}, {7'b0, exp_ferr});
    end
  end

  task automatic push_ev(input int at, input int kind, input logic [7:0] b, input logic pe_err, input logic fr_err);
    ev_t e;
    e.at = at; e.kind = kind; e.b = b; e.pe_err = pe_err; e.fr_err = fr_err;
    evq.push_back(e);
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  function automatic logic good_par(input logic [7:0] b, input logic odd);
    return (($countones(b) % 2) == 0) ? odd : !odd;
  endfunction

  // Called aligned at posedge+1; returns aligned at the end of the last stop bit (or later if re-enabling).
  task automatic send_frame(input logic [7:0] b, input logic f_pe, input logic f_ps, input logic f_pbit,
                            input logic f_st2, input logic f_s1, input logic f_s2, input bit drop_en_in);
    logic bits[$];
    int   s, nb;
    bit   drop_en, accepted;
    logic e_perr, e_ferr;
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (f_pe) bits.push_back(f_pbit);
    bits.push_back(f_s1);
    if (f_st2) bits.push_back(f_s2);
    nb = bits.size();
    e_perr = f_pe && ((($countones(b) + int'(f_pbit)) % 2) != int'(f_ps));
    e_ferr = !f_s1 || (f_st2 && !f_s2);
    // A low final stop would otherwise be taken as the next start bit.
    drop_en = drop_en_in || e_ferr;
    accepted = enable;
    pe = f_pe; ps = f_ps; st2 = f_st2;
    s = cyc;
    if (accepted) begin
      push_ev(s + 3, EV_START, 8'h00, 1'b0, 1'b0);
      push_ev(s + 3 + HALF + (nb - 1) * BIT, EV_END, b, e_perr, e_ferr);
    end
    for (int j = 0; j < nb; j++) begin
      rx = bits[j];
      if (j == 5) begin
        pe = 1'($urandom); ps = 1'($urandom); st2 = 1'($urandom);
        if (drop_en && accepted) enable = 1'b0;
      end
      repeat (BIT) @(posedge clk);
      #1;
      if (accepted && f_st2 && j == nb - 2) cmp("busy_in_stop2", {7'b0, busy}, 8'h01);
    end
    rx = 1'b1;
    if (drop_en && accepted) begin
      idle(3);
      enable = 1'b1;
    end
  endtask

  task automatic glitch();
    int s;
    s = cyc;
    rx = 1'b0;
    if (enable) begin
      push_ev(s + 3, EV_START, 8'h00, 1'b0, 1'b0);
      push_ev(s + 3 + HALF, EV_FALSE, 8'h00, 1'b0, 1'b0);
    end
    idle(BIT / 4);
    rx = 1'b1;
    idle(2 * BIT);
  endtask

  logic [7:0] hello [5];

  initial begin
    hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;
    rst = 1'b1;
    idle(3);
    cmp("rst_data", data, 8'h00);
    cmp("rst_busy", {7'b0, busy}, 8'h00);
    cmp("rst_ready", {7'b0, ready}, 8'h00);
    cmp("rst_perr", {7'b0, perr}, 8'h00);
    cmp("rst_ferr", {7'b0, ferr}, 8'h00);
    rst = 1'b0;
    chk_on = 1'b1;
    enable = 1'b1;
    idle(5);

    glitch();
    cmp("glitch_busy", {7'b0, busy}, 8'h00);
    cmp("glitch_ready", {7'b0, ready}, 8'h00);

    for (int i = 0; i < 5; i++) begin
      send_frame(hello[i], 1'b1, 1'b1, good_par(hello[i], 1'b1), 1'b0, 1'b1, 1'b1, 1'b0);
      cmp("hello_busy", {7'b0, busy}, 8'h00);
      cmp("hello_ready", {7'b0, ready}, 8'h01);
      cmp("hello_data", data, hello[i]);
      cmp("hello_perr", {7'b0, perr}, 8'h00);
    end
    idle(4);

    send_frame(8'h48, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cmp("odd_p0_perr", {7'b0, perr}, 8'h01);
    cmp("odd_p0_data", data, 8'h48);
    send_frame(8'h48, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cmp("odd_p1_perr", {7'b0, perr}, 8'h00);
    send_frame(8'h48, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cmp("even_p0_perr", {7'b0, perr}, 8'h00);

    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cmp("frm_ferr", {7'b0, ferr}, 8'h01);
    cmp("frm_ready", {7'b0, ready}, 8'h01);
    cmp("frm_data", data, 8'hA5);

    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cmp("stop2_low_ferr", {7'b0, ferr}, 8'h01);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cmp("stop2_ok_ferr", {7'b0, ferr}, 8'h00);
    cmp("stop2_ok_data", data, 8'h3C);

    enable = 1'b0;
    send_frame(8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cmp("dis_data", data, 8'h3C);
    cmp("dis_ready", {7'b0, ready}, 8'h01);
    enable = 1'b1;
    idle(5);

    // Reset while the receiver is in the data bits.
    begin
      int s;
      s = cyc;
      rx = 1'b0;
      push_ev(s + 3, EV_START, 8'h00, 1'b0, 1'b0);
      idle(3 * BIT);
      rst = 1'b1;
      #1;
      cmp("midrst_busy", {7'b0, busy}, 8'h00);
      cmp("midrst_data", data, 8'h00);
      cmp("midrst_ready", {7'b0, ready}, 8'h00);
      rx = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(4);
    end
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cmp("post_rst_data", data, 8'h55);
    cmp("post_rst_ready", {7'b0, ready}, 8'h01);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      logic f_pe, f_ps, f_pbit, f_st2, f_s1, f_s2;
      b      = 8'($urandom);
      f_pe   = 1'($urandom);
      f_ps   = 1'($urandom);
      f_pbit = good_par(b, f_ps) ^ (($urandom % 4) == 0);
      f_st2  = 1'($urandom);
      f_s1   = ($urandom % 6) != 0;
      f_s2   = ($urandom % 6) != 0;
      send_frame(b, f_pe, f_ps, f_pbit, f_st2, f_s1, f_s2, ($urandom % 3) == 0);
      idle($urandom % 15);
    end
    idle(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    bad++;
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
